// File: rtl/alu_mdu.sv
// alu_mdu: registered WIDTH-bit ALU with iterative signed/unsigned multiply/divide and HI/LO registers.
// Build option: define ALU_MDU_DIV_EN to include the divide datapath (ops 16/17); otherwise they act as illegal ops.
module alu_mdu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_ALU_valid,
   output logic             o_ALU_ready,
   input  logic [4:0]       i_ALU_op,
   input  logic [WIDTH-1:0] i_ALU_srcA,
   input  logic [WIDTH-1:0] i_ALU_srcB,
   output logic             o_ALU_valid,
   output logic [WIDTH-1:0] o_ALU_aluOut,
   output logic             o_ALU_zero,
   output logic [WIDTH-1:0] o_ALU_hi,
   output logic [WIDTH-1:0] o_ALU_lo
);
   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [4:0] OP_ADD   = 5'd1;
   localparam logic [4:0] OP_SUB   = 5'd2;
   localparam logic [4:0] OP_AND   = 5'd3;
   localparam logic [4:0] OP_OR    = 5'd4;
   localparam logic [4:0] OP_XOR   = 5'd5;
   localparam logic [4:0] OP_NOR   = 5'd6;
   localparam logic [4:0] OP_CMP   = 5'd7;
   localparam logic [4:0] OP_CMPU  = 5'd8;
   localparam logic [4:0] OP_SL    = 5'd9;
   localparam logic [4:0] OP_SR    = 5'd10;
   localparam logic [4:0] OP_SRA   = 5'd11;
   localparam logic [4:0] OP_LUI   = 5'd12;
   localparam logic [4:0] OP_XAL   = 5'd13;
   localparam logic [4:0] OP_MULT  = 5'd14;
   localparam logic [4:0] OP_MULTU = 5'd15;
`ifdef ALU_MDU_DIV_EN
   localparam logic [4:0] OP_DIV   = 5'd16;
   localparam logic [4:0] OP_DIVU  = 5'd17;
`endif

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

   state_e               state_q;
   logic [CW-1:0]        cnt_q;
   logic                 ready_q;
   logic                 valid_q;
   logic [WIDTH-1:0]     out_q;
   logic                 zero_q;
   logic [WIDTH-1:0]     hi_q;
   logic [WIDTH-1:0]     lo_q;
   // p_q holds {partial product | remainder, multiplier | quotient}
   logic [2*WIDTH-1:0]   p_q;
   logic [WIDTH-1:0]     mcand_q;
   logic                 neg_lo_q;
`ifdef ALU_MDU_DIV_EN
   logic                 is_div_q;
   logic                 neg_hi_q;
   logic                 div0_q;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH:0]       trial_s;
   logic [WIDTH:0]       diff_s;
`endif

   logic                 is_mul_s;
   logic                 is_div_s;
   logic                 signed_s;
   logic                 start_s;
   logic                 neg_a_s;
   logic                 neg_b_s;
   logic [WIDTH-1:0]     abs_a_s;
   logic [WIDTH-1:0]     abs_b_s;
   logic [WIDTH-1:0]     alu_res_s;
   logic [WIDTH:0]       add_s;
   logic [2*WIDTH-1:0]   p_d;
   logic [2*WIDTH-1:0]   prod_s;
   logic [WIDTH-1:0]     fix_hi_s;
   logic [WIDTH-1:0]     fix_lo_s;

   // Decode multi-cycle ops and form operand magnitudes for the iterative unit
   always_comb begin
      is_mul_s = (i_ALU_op == OP_MULT) || (i_ALU_op == OP_MULTU);
`ifdef ALU_MDU_DIV_EN
      is_div_s = (i_ALU_op == OP_DIV) || (i_ALU_op == OP_DIVU);
      signed_s = (i_ALU_op == OP_MULT) || (i_ALU_op == OP_DIV);
`else
      is_div_s = 1'b0;
      signed_s = (i_ALU_op == OP_MULT);
`endif
      start_s  = is_mul_s || is_div_s;
      neg_a_s  = signed_s && i_ALU_srcA[WIDTH-1];
      neg_b_s  = signed_s && i_ALU_srcB[WIDTH-1];
      abs_a_s  = neg_a_s ? ({WIDTH{1'b0}} - i_ALU_srcA) : i_ALU_srcA;
      abs_b_s  = neg_b_s ? ({WIDTH{1'b0}} - i_ALU_srcB) : i_ALU_srcB;
   end

   // Single-cycle ALU result; illegal and multi-cycle opcodes yield zero here
   always_comb begin
      alu_res_s = {WIDTH{1'b0}};
      case (i_ALU_op)
         OP_ADD:  alu_res_s = i_ALU_srcA + i_ALU_srcB;
         OP_SUB:  alu_res_s = i_ALU_srcA - i_ALU_srcB;
         OP_AND:  alu_res_s = i_ALU_srcA & i_ALU_srcB;
         OP_OR:   alu_res_s = i_ALU_srcA | i_ALU_srcB;
         OP_XOR:  alu_res_s = i_ALU_srcA ^ i_ALU_srcB;
         OP_NOR:  alu_res_s = ~(i_ALU_srcA | i_ALU_srcB);
         OP_CMP:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(i_ALU_srcA) < $signed(i_ALU_srcB))};
         OP_CMPU: alu_res_s = {{(WIDTH-1){1'b0}}, (i_ALU_srcA < i_ALU_srcB)};
         OP_SL:   alu_res_s = i_ALU_srcB << i_ALU_srcA[SHW-1:0];
         OP_SR:   alu_res_s = i_ALU_srcB >> i_ALU_srcA[SHW-1:0];
         OP_SRA:  alu_res_s = $signed(i_ALU_srcB) >>> i_ALU_srcA[SHW-1:0];
         OP_LUI:  alu_res_s = i_ALU_srcB << (WIDTH/2);
         OP_XAL:  alu_res_s = i_ALU_srcA + {{(WIDTH-4){1'b0}}, 4'd8};
         default: alu_res_s = {WIDTH{1'b0}};
      endcase
   end

   // One shift-add (multiply) or restoring-subtract (divide) step on unsigned magnitudes
   always_comb begin
      add_s = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
      p_d   = {add_s, p_q[WIDTH-1:1]};
`ifdef ALU_MDU_DIV_EN
      trial_s = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
      diff_s  = trial_s - {1'b0, mcand_q};
      if (is_div_q) begin
         if (diff_s[WIDTH]) begin
            p_d = {trial_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
         end else begin
            p_d = {diff_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
         end
      end else begin
         p_d = {add_s, p_q[WIDTH-1:1]};
      end
`endif
   end

   // Sign correction and special cases applied in the FIX state
   always_comb begin
      prod_s   = neg_lo_q ? ({(2*WIDTH){1'b0}} - p_q) : p_q;
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
`ifdef ALU_MDU_DIV_EN
      if (is_div_q) begin
         if (div0_q) begin
            fix_lo_s = {WIDTH{1'b1}};
            fix_hi_s = a_q;
         end else begin
            fix_lo_s = neg_lo_q ? ({WIDTH{1'b0}} - p_q[WIDTH-1:0]) : p_q[WIDTH-1:0];
            fix_hi_s = neg_hi_q ? ({WIDTH{1'b0}} - p_q[2*WIDTH-1:WIDTH]) : p_q[2*WIDTH-1:WIDTH];
         end
      end else begin
         fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      end
`endif
   end

   // Control FSM with registered handshake and result outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= {CW{1'b0}};
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
         out_q    <= {WIDTH{1'b0}};
         zero_q   <= 1'b1;
         hi_q     <= {WIDTH{1'b0}};
         lo_q     <= {WIDTH{1'b0}};
         p_q      <= {(2*WIDTH){1'b0}};
         mcand_q  <= {WIDTH{1'b0}};
         neg_lo_q <= 1'b0;
`ifdef ALU_MDU_DIV_EN
         is_div_q <= 1'b0;
         neg_hi_q <= 1'b0;
         div0_q   <= 1'b0;
         a_q      <= {WIDTH{1'b0}};
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_ALU_valid && ready_q) begin
                  if (start_s) begin
                     state_q  <= S_CALC;
                     cnt_q    <= {CW{1'b0}};
                     ready_q  <= 1'b0;
                     valid_q  <= 1'b0;
                     p_q      <= {{WIDTH{1'b0}}, abs_a_s};
                     mcand_q  <= abs_b_s;
                     neg_lo_q <= neg_a_s ^ neg_b_s;
`ifdef ALU_MDU_DIV_EN
                     is_div_q <= is_div_s;
                     neg_hi_q <= neg_a_s;
                     div0_q   <= (i_ALU_srcB == {WIDTH{1'b0}});
                     a_q      <= i_ALU_srcA;
`endif
                  end else begin
                     valid_q <= 1'b1;
                     out_q   <= alu_res_s;
                     zero_q  <= (alu_res_s == {WIDTH{1'b0}});
                  end
               end else begin
                  valid_q <= 1'b0;
               end
            end
            S_CALC: begin
               p_q   <= p_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               hi_q    <= fix_hi_s;
               lo_q    <= fix_lo_s;
               out_q   <= fix_lo_s;
               zero_q  <= (fix_lo_s == {WIDTH{1'b0}});
               valid_q <= 1'b1;
               ready_q <= 1'b1;
               cnt_q   <= {CW{1'b0}};
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_ALU_ready  = ready_q;
   assign o_ALU_valid  = valid_q;
   assign o_ALU_aluOut = out_q;
   assign o_ALU_zero   = zero_q;
   assign o_ALU_hi     = hi_q;
   assign o_ALU_lo     = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Testbench for alu_mdu: directed and randomized ops against an arithmetic reference model (WIDTH=32),
// plus a few directed checks on a WIDTH=16 instance.
module tb_alu_mdu;
   logic        clk = 1'b0;
   logic        rst;

   logic        v32, r32, ov32, z32;
   logic [4:0]  op32;
   logic [31:0] a32, b32, out32, hi32, lo32;

   logic        v16, r16, ov16, z16;
   logic [4:0]  op16;
   logic [15:0] a16, b16, out16, hi16, lo16;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] exp_hi, exp_lo, exp_out;

`ifdef ALU_MDU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   typedef struct packed {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } vec_t;

   vec_t dir_v [16] = '{
      '{5'd1,  32'hfffffffa, 32'h0000000b},
      '{5'd2,  32'h00000123, 32'h00000123},
      '{5'd7,  32'hffffffff, 32'h00000000},
      '{5'd8,  32'hffffffff, 32'h00000000},
      '{5'd11, 32'h00000005, 32'hf2345678},
      '{5'd12, 32'h00000000, 32'h12345678},
      '{5'd14, 32'hfffffffe, 32'h00000003},
      '{5'd15, 32'hfffffffe, 32'h00000003},
      '{5'd16, 32'hfffffff9, 32'h00000002},
      '{5'd17, 32'h00001234, 32'h00000000},
      '{5'd16, 32'h80000000, 32'hffffffff},
      '{5'd0,  32'h00000005, 32'h00000006},
      '{5'd20, 32'h00000001, 32'h00000002},
      '{5'd13, 32'h00000010, 32'h00000000},
      '{5'd9,  32'h00000004, 32'h00000001},
      '{5'd6,  32'hf0f0f0f0, 32'h0f0f0f00}
   };

   alu_mdu u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_ALU_valid  (v32),
      .o_ALU_ready  (r32),
      .i_ALU_op     (op32),
      .i_ALU_srcA   (a32),
      .i_ALU_srcB   (b32),
      .o_ALU_valid  (ov32),
      .o_ALU_aluOut (out32),
      .o_ALU_zero   (z32),
      .o_ALU_hi     (hi32),
      .o_ALU_lo     (lo32)
   );

   alu_mdu #(.WIDTH(16)) u_dut16 (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_ALU_valid  (v16),
      .o_ALU_ready  (r16),
      .i_ALU_op     (op16),
      .i_ALU_srcA   (a16),
      .i_ALU_srcB   (b16),
      .o_ALU_valid  (ov16),
      .o_ALU_aluOut (out16),
      .o_ALU_zero   (z16),
      .o_ALU_hi     (hi16),
      .o_ALU_lo     (lo16)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference behaviour: result, latency and HI/LO effect of one op
   task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat);
      longint      sp;
      logic [63:0] up;
      int          sa, sb;
      sa  = a;
      sb  = b;
      lat = 1;
      r   = 32'd0;
      case (op)
         5'd1:  r = a + b;
         5'd2:  r = a - b;
         5'd3:  r = a & b;
         5'd4:  r = a | b;
         5'd5:  r = a ^ b;
         5'd6:  r = ~(a | b);
         5'd7:  r = {31'd0, (sa < sb)};
         5'd8:  r = {31'd0, (a < b)};
         5'd9:  r = b << a[4:0];
         5'd10: r = b >> a[4:0];
         5'd11: r = sb >>> a[4:0];
         5'd12: r = b << 16;
         5'd13: r = a + 32'd8;
         5'd14: begin
            sp = longint'(sa) * longint'(sb);
            exp_hi = sp[63:32]; exp_lo = sp[31:0]; lat = 34; r = exp_lo;
         end
         5'd15: begin
            up = {32'h0, a} * {32'h0, b};
            exp_hi = up[63:32]; exp_lo = up[31:0]; lat = 34; r = exp_lo;
         end
         5'd16, 5'd17: begin
            if (DIV_EN) begin
               lat = 34;
               if (b == 32'd0) begin
                  exp_lo = 32'hffffffff; exp_hi = a;
               end else if (op == 5'd16 && a == 32'h80000000 && b == 32'hffffffff) begin
                  exp_lo = a; exp_hi = 32'd0;
               end else if (op == 5'd16) begin
                  exp_lo = 32'(sa / sb); exp_hi = 32'(sa % sb);
               end else begin
                  exp_lo = a / b; exp_hi = a % b;
               end
               r = exp_lo;
            end
         end
         default: r = 32'd0;
      endcase
      exp_out = r;
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 7))
         0:       return 32'h00000000;
         1:       return 32'hffffffff;
         2:       return 32'h80000000;
         3:       return 32'h7fffffff;
         4:       return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   // Issue one op at the current negedge and check handshake, latency and results
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] e_out;
      int          e_lat;
      int          k;
      bit          seen;
      model(op, a, b, e_out, e_lat);
      v32 = 1'b1; op32 = op; a32 = a; b32 = b;
      k = 0; seen = 1'b0;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         if (ov32 === 1'b1) begin
            seen = 1'b1;
         end else begin
            chk("busy_ready", 64'(r32), 64'd0);
            v32 = 1'($urandom_range(0, 1)); op32 = 5'($urandom_range(0, 31));
            a32 = $urandom; b32 = $urandom;
         end
      end
      chk("latency", 64'(seen ? k : 0), 64'(e_lat));
      chk("aluOut", 64'(out32), 64'(e_out));
      chk("zero", 64'(z32), 64'(e_out == 32'd0));
      chk("hi", 64'(hi32), 64'(exp_hi));
      chk("lo", 64'(lo32), 64'(exp_lo));
      chk("ready_done", 64'(r32), 64'd1);
   endtask

   task automatic idle1();
      v32 = 1'b0; op32 = 5'($urandom_range(0, 31)); a32 = $urandom; b32 = $urandom;
      @(negedge clk);
      chk("idle_valid", 64'(ov32), 64'd0);
      chk("idle_ready", 64'(r32), 64'd1);
      chk("idle_hold", 64'(out32), 64'(exp_out));
   endtask

   task automatic issue16(input string tag, input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int e_lat, input logic [15:0] e_out, input logic [15:0] e_hi, input logic [15:0] e_lo);
      int k;
      bit seen;
      v16 = 1'b1; op16 = op; a16 = a; b16 = b;
      k = 0; seen = 1'b0;
      while (!seen && k < 25) begin
         @(negedge clk);
         k++;
         if (ov16 === 1'b1) seen = 1'b1;
         else v16 = 1'b0;
      end
      v16 = 1'b0;
      chk({tag, "_lat"}, 64'(seen ? k : 0), 64'(e_lat));
      chk({tag, "_out"}, 64'(out16), 64'(e_out));
      chk({tag, "_hi"}, 64'(hi16), 64'(e_hi));
      chk({tag, "_lo"}, 64'(lo16), 64'(e_lo));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] rop;
      rst = 1'b1;
      v32 = 1'b0; op32 = 5'd0; a32 = 32'd0; b32 = 32'd0;
      v16 = 1'b0; op16 = 5'd0; a16 = 16'd0; b16 = 16'd0;
      exp_hi = 32'd0; exp_lo = 32'd0; exp_out = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 64'(r32), 64'd1);
      chk("rst_valid", 64'(ov32), 64'd0);
      chk("rst_out", 64'(out32), 64'd0);
      chk("rst_zero", 64'(z32), 64'd1);
      chk("rst_hi", 64'(hi32), 64'd0);
      chk("rst_lo", 64'(lo32), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         issue(dir_v[i].op, dir_v[i].a, dir_v[i].b);
      end
      idle1();

      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 3) == 0) rop = 5'(14 + $urandom_range(0, 3));
         else rop = 5'($urandom_range(0, 31));
         issue(rop, rnd_opnd(), rnd_opnd());
         if ($urandom_range(0, 3) == 0) idle1();
      end

      // Abort a multiply with reset; a request held high while busy must be ignored
      v32 = 1'b1; op32 = 5'd14; a32 = 32'h12345678; b32 = 32'h9abcdef0;
      @(negedge clk);
      op32 = 5'd1; a32 = 32'd1; b32 = 32'd1;
      repeat (9) @(negedge clk);
      chk("pre_rst_busy", 64'({ov32, r32}), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ready", 64'(r32), 64'd1);
      chk("abort_valid", 64'(ov32), 64'd0);
      chk("abort_out", 64'(out32), 64'd0);
      chk("abort_zero", 64'(z32), 64'd1);
      chk("abort_hi", 64'(hi32), 64'd0);
      chk("abort_lo", 64'(lo32), 64'd0);
      exp_hi = 32'd0; exp_lo = 32'd0; exp_out = 32'd0;
      issue(5'd1, 32'd7, 32'd9);
      idle1();
      idle1();

      issue16("w16_sl",   5'd9,  16'h0013, 16'h0001, 1,  16'h0008, 16'h0000, 16'h0000);
      issue16("w16_lui",  5'd12, 16'h0000, 16'h1234, 1,  16'h3400, 16'h0000, 16'h0000);
      issue16("w16_mult", 5'd14, 16'h7fff, 16'h7fff, 18, 16'h0001, 16'h3fff, 16'h0001);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
